// File: rtl/nf_tx_pkg.sv
// nf_tx_pkg: shared widths and types for the
// two-source 10G MAC TX arbiter.
package nf_tx_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int CNT_W       = 32;
  localparam int GAP_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_GAP
  } tx_state_e;

  typedef enum logic {
    SRC_A,
    SRC_B
  } tx_src_e;

endpackage

// File: rtl/nf_tx_arbiter.sv
// nf_tx_arbiter: frame-granular round-robin share
// of the MAC TX stream between sources A and B.
module nf_tx_arbiter
  import nf_tx_pkg::*;
#(
  parameter int         IFG_CYCLES   = 0,
  parameter logic [7:0] TX_IFG_DELAY = 8'd0
) (
  input  logic                   clk156,
  input  logic                   reset,
  input  logic [AXIS_DATA_W-1:0] a_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] a_axis_tkeep,
  input  logic                   a_axis_tlast,
  input  logic                   a_axis_tvalid,
  output logic                   a_axis_tready,
  input  logic [AXIS_DATA_W-1:0] b_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] b_axis_tkeep,
  input  logic                   b_axis_tlast,
  input  logic                   b_axis_tvalid,
  output logic                   b_axis_tready,
  output logic [AXIS_DATA_W-1:0] s_axis_tx_tdata,
  output logic [AXIS_KEEP_W-1:0] s_axis_tx_tkeep,
  output logic                   s_axis_tx_tlast,
  output logic                   s_axis_tx_tvalid,
  input  logic                   s_axis_tx_tready,
  output logic [7:0]             tx_ifg_delay,
  output logic [CNT_W-1:0]       pkt_cnt_a,
  output logic [CNT_W-1:0]       pkt_cnt_b
);

  localparam logic [GAP_W-1:0] IFG_LD = GAP_W'(IFG_CYCLES);

  tx_state_e        state_q, state_d;
  tx_src_e          grant_q, grant_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic             done_a, done_b;

  // Next state, grant choice and the combinational data path.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    gap_d            = gap_q;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    a_axis_tready    = 1'b0;
    b_axis_tready    = 1'b0;
    done_a           = 1'b0;
    done_b           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (a_axis_tvalid &&
            (!b_axis_tvalid || grant_q == SRC_B)) begin
          state_d = ST_SEND_A;
          grant_d = SRC_A;
        end else if (b_axis_tvalid) begin
          state_d = ST_SEND_B;
          grant_d = SRC_B;
        end
      end
      ST_SEND_A: begin
        s_axis_tx_tdata  = a_axis_tdata;
        s_axis_tx_tkeep  = a_axis_tkeep;
        s_axis_tx_tlast  = a_axis_tlast;
        s_axis_tx_tvalid = a_axis_tvalid;
        a_axis_tready    = s_axis_tx_tready;
        done_a = a_axis_tvalid && s_axis_tx_tready
                 && a_axis_tlast;
      end
      ST_SEND_B: begin
        s_axis_tx_tdata  = b_axis_tdata;
        s_axis_tx_tkeep  = b_axis_tkeep;
        s_axis_tx_tlast  = b_axis_tlast;
        s_axis_tx_tvalid = b_axis_tvalid;
        b_axis_tready    = s_axis_tx_tready;
        done_b = b_axis_tvalid && s_axis_tx_tready
                 && b_axis_tlast;
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_a || done_b) begin
      if (IFG_CYCLES == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_GAP;
        gap_d   = IFG_LD;
      end
    end
  end

  // Control flops and per-source frame counters.
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= SRC_B;
      gap_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      if (done_a) begin
        cnt_a_q <= cnt_a_q + CNT_W'(1);
      end
      if (done_b) begin
        cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
    end
  end

  assign tx_ifg_delay = TX_IFG_DELAY;
  assign pkt_cnt_a    = cnt_a_q;
  assign pkt_cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_nf_tx_arbiter.sv
// tb_nf_tx_arbiter: directed tables, corner sequences
// and random traffic against a behavioural model.
module tb_nf_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_d [2];
  logic [63:0] b_d [2];
  logic [7:0]  a_k [2];
  logic [7:0]  b_k [2];
  logic        a_l [2];
  logic        b_l [2];
  logic        a_v [2];
  logic        b_v [2];
  logic        a_r [2];
  logic        b_r [2];
  logic [63:0] o_d [2];
  logic [7:0]  o_k [2];
  logic        o_l [2];
  logic        o_v [2];
  logic        rdy [2];
  logic [7:0]  ifgd [2];
  logic [31:0] ca [2];
  logic [31:0] cb [2];

  int checks   = 0;
  int failures = 0;

  nf_tx_arbiter #(
    .IFG_CYCLES(0), .TX_IFG_DELAY(8'h0C)
  ) dut0 (
    .clk156(clk), .reset(rst),
    .a_axis_tdata(a_d[0]), .a_axis_tkeep(a_k[0]),
    .a_axis_tlast(a_l[0]), .a_axis_tvalid(a_v[0]),
    .a_axis_tready(a_r[0]),
    .b_axis_tdata(b_d[0]), .b_axis_tkeep(b_k[0]),
    .b_axis_tlast(b_l[0]), .b_axis_tvalid(b_v[0]),
    .b_axis_tready(b_r[0]),
    .s_axis_tx_tdata(o_d[0]), .s_axis_tx_tkeep(o_k[0]),
    .s_axis_tx_tlast(o_l[0]), .s_axis_tx_tvalid(o_v[0]),
    .s_axis_tx_tready(rdy[0]),
    .tx_ifg_delay(ifgd[0]),
    .pkt_cnt_a(ca[0]), .pkt_cnt_b(cb[0])
  );

  nf_tx_arbiter #(
    .IFG_CYCLES(4), .TX_IFG_DELAY(8'h05)
  ) dut1 (
    .clk156(clk), .reset(rst),
    .a_axis_tdata(a_d[1]), .a_axis_tkeep(a_k[1]),
    .a_axis_tlast(a_l[1]), .a_axis_tvalid(a_v[1]),
    .a_axis_tready(a_r[1]),
    .b_axis_tdata(b_d[1]), .b_axis_tkeep(b_k[1]),
    .b_axis_tlast(b_l[1]), .b_axis_tvalid(b_v[1]),
    .b_axis_tready(b_r[1]),
    .s_axis_tx_tdata(o_d[1]), .s_axis_tx_tkeep(o_k[1]),
    .s_axis_tx_tlast(o_l[1]), .s_axis_tx_tvalid(o_v[1]),
    .s_axis_tx_tready(rdy[1]),
    .tx_ifg_delay(ifgd[1]),
    .pkt_cnt_a(ca[1]), .pkt_cnt_b(cb[1])
  );

  function automatic int ifg_of(int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic logic [7:0] dly_of(int i);
    return (i == 0) ? 8'h0C : 8'h05;
  endfunction

  // Reference model: who owns the MAC (0 none,
  // 1 A, 2 B), quiet cycles left, and whether A
  // wins the next tie.
  int          m_src [2];
  int          m_quiet [2];
  bit          m_a_first [2];
  logic [31:0] m_ca [2];
  logic [31:0] m_cb [2];
  bit          m_ok = 1'b0;
  logic [3:0]  own [2];
  bit          hs_a [2];
  bit          hs_b [2];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        ev, el, ear, ebr;
      ed = '0; ek = '0;
      ev = 1'b0; el = 1'b0;
      ear = 1'b0; ebr = 1'b0;
      if (m_src[i] == 1) begin
        ed = a_d[i]; ek = a_k[i];
        ev = a_v[i]; el = a_l[i]; ear = rdy[i];
      end else if (m_src[i] == 2) begin
        ed = b_d[i]; ek = b_k[i];
        ev = b_v[i]; el = b_l[i]; ebr = rdy[i];
      end
      chk($sformatf("u%0d_tvalid", i),
          64'(o_v[i]), 64'(ev));
      chk($sformatf("u%0d_tdata", i), o_d[i], ed);
      chk($sformatf("u%0d_tkeep", i),
          64'(o_k[i]), 64'(ek));
      chk($sformatf("u%0d_tlast", i),
          64'(o_l[i]), 64'(el));
      chk($sformatf("u%0d_a_tready", i),
          64'(a_r[i]), 64'(ear));
      chk($sformatf("u%0d_b_tready", i),
          64'(b_r[i]), 64'(ebr));
      chk($sformatf("u%0d_ifg_delay", i),
          64'(ifgd[i]), 64'(dly_of(i)));
      chk($sformatf("u%0d_pkt_cnt_a", i),
          64'(ca[i]), 64'(m_ca[i]));
      chk($sformatf("u%0d_pkt_cnt_b", i),
          64'(cb[i]), 64'(m_cb[i]));
    end
  endtask

  // A frame seen on the MAC side must come from one
  // source from its first beat to its tlast beat.
  task automatic track_frames();
    for (int i = 0; i < 2; i++) begin
      if (o_v[i] && rdy[i]) begin
        if (own[i] != 4'h0) begin
          chk($sformatf("u%0d_frame_src", i),
              64'(o_d[i][63:60]), 64'(own[i]));
        end
        own[i] = o_l[i] ? 4'h0 : o_d[i][63:60];
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_src[i] = 0;
        m_quiet[i] = 0;
        m_a_first[i] = 1'b1;
        m_ca[i] = '0;
        m_cb[i] = '0;
        own[i] = 4'h0;
      end else if (m_src[i] == 1) begin
        if (a_v[i] && rdy[i] && a_l[i]) begin
          m_ca[i] = m_ca[i] + 32'd1;
          m_src[i] = 0;
          m_quiet[i] = ifg_of(i);
        end
      end else if (m_src[i] == 2) begin
        if (b_v[i] && rdy[i] && b_l[i]) begin
          m_cb[i] = m_cb[i] + 32'd1;
          m_src[i] = 0;
          m_quiet[i] = ifg_of(i);
        end
      end else if (m_quiet[i] > 0) begin
        m_quiet[i]--;
      end else if (a_v[i] &&
                   (!b_v[i] || m_a_first[i])) begin
        m_src[i] = 1;
        m_a_first[i] = 1'b0;
      end else if (b_v[i]) begin
        m_src[i] = 2;
        m_a_first[i] = 1'b1;
      end
    end
    if (rst) m_ok = 1'b1;
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      hs_a[i] = a_v[i] && a_r[i];
      hs_b[i] = b_v[i] && b_r[i];
    end
    if (m_ok) begin
      check_model();
      track_frames();
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in(input int i);
    a_v[i] = 1'b0; b_v[i] = 1'b0;
    a_l[i] = 1'b0; b_l[i] = 1'b0;
    a_d[i] = '0;   b_d[i] = '0;
    a_k[i] = '0;   b_k[i] = '0;
    rdy[i] = 1'b1;
  endtask

  typedef struct {
    bit av, al, bv, bl;
    bit ev, el, ear, ebr;
    int src;
  } vec_t;

  function automatic vec_t mk(bit av, bit al,
                              bit bv, bit bl,
                              bit ev, bit el,
                              bit ear, bit ebr,
                              int src);
    vec_t v;
    v.av = av; v.al = al; v.bv = bv; v.bl = bl;
    v.ev = ev; v.el = el; v.ear = ear; v.ebr = ebr;
    v.src = src;
    return v;
  endfunction

  // Random source state: [inst][0=A,1=B]
  int slen [2][2];
  int sbt  [2][2];
  int sfr  [2][2];
  int sdone [2][2];

  task automatic drive_rand(input int i);
    for (int s = 0; s < 2; s++) begin
      logic        v, l;
      logic [63:0] d;
      logic [7:0]  k;
      v = ($urandom_range(0, 9) < 7);
      d = {(s == 1) ? 4'hB : 4'hA, 4'(i),
           16'(sfr[i][s]), 8'(sbt[i][s]),
           $urandom()};
      k = 8'($urandom());
      l = (sbt[i][s] == slen[i][s] - 1);
      if (s == 0) begin
        a_v[i] = v; a_d[i] = d;
        a_k[i] = k; a_l[i] = l;
      end else begin
        b_v[i] = v; b_d[i] = d;
        b_k[i] = k; b_l[i] = l;
      end
    end
    rdy[i] = ($urandom_range(0, 9) < 8);
  endtask

  task automatic advance_rand(input int i);
    for (int s = 0; s < 2; s++) begin
      bit hs;
      hs = (s == 0) ? hs_a[i] : hs_b[i];
      if (hs) begin
        if (sbt[i][s] == slen[i][s] - 1)
          sdone[i][s]++;
        sbt[i][s]++;
        if (sbt[i][s] == slen[i][s]) begin
          sbt[i][s] = 0;
          slen[i][s] = $urandom_range(1, 4);
          sfr[i][s]++;
        end
      end
    end
  endtask

  vec_t tbl [12];
  int   bt, rc;
  logic [63:0] exp_d;

  initial begin
    rst = 1'b1;
    idle_in(0);
    idle_in(1);
    tick();
    tick();
    rst = 1'b0;

    // Reset values on both instances.
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", 64'(o_v[i]), 64'd0);
      chk("rst_tdata", o_d[i], 64'd0);
      chk("rst_tkeep", 64'(o_k[i]), 64'd0);
      chk("rst_tlast", 64'(o_l[i]), 64'd0);
      chk("rst_a_tready", 64'(a_r[i]), 64'd0);
      chk("rst_b_tready", 64'(b_r[i]), 64'd0);
      chk("rst_cnt_a", 64'(ca[i]), 64'd0);
      chk("rst_cnt_b", 64'(cb[i]), 64'd0);
      chk("rst_ifg_delay", 64'(ifgd[i]),
          64'(dly_of(i)));
    end
    tick();

    // Tie-break and alternation, IFG 0, 2-beat frames.
    tbl[0] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 1, 0, 1, 0, 1);
    tbl[2] = mk(1, 1, 1, 0, 1, 1, 1, 0, 1);
    tbl[3] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 1, 0, 1, 0, 0, 1, 2);
    tbl[5] = mk(1, 0, 1, 1, 1, 1, 0, 1, 2);
    for (int r = 6; r < 12; r++) tbl[r] = tbl[r - 6];
    for (int r = 0; r < 12; r++) begin
      a_v[0] = tbl[r].av; a_l[0] = tbl[r].al;
      b_v[0] = tbl[r].bv; b_l[0] = tbl[r].bl;
      a_d[0] = {4'hA, 60'(r)}; a_k[0] = 8'hFF;
      b_d[0] = {4'hB, 60'(r)}; b_k[0] = 8'h0F;
      rdy[0] = 1'b1;
      #1;
      exp_d = (tbl[r].src == 1) ? a_d[0] :
              (tbl[r].src == 2) ? b_d[0] : 64'd0;
      chk($sformatf("tbl%0d_tvalid", r),
          64'(o_v[0]), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_tlast", r),
          64'(o_l[0]), 64'(tbl[r].el));
      chk($sformatf("tbl%0d_a_tready", r),
          64'(a_r[0]), 64'(tbl[r].ear));
      chk($sformatf("tbl%0d_b_tready", r),
          64'(b_r[0]), 64'(tbl[r].ebr));
      chk($sformatf("tbl%0d_tdata", r),
          o_d[0], exp_d);
      tick();
    end
    idle_in(0);
    #1;
    chk("alt_cnt_a", 64'(ca[0]), 64'd2);
    chk("alt_cnt_b", 64'(cb[0]), 64'd2);
    tick();

    // Single source: 3-beat A frame, B idle.
    for (int c = 0; c < 5; c++) begin
      bt = (c == 0) ? 0 : c - 1;
      a_v[0] = (c <= 3);
      a_d[0] = {4'hA, 60'h100 + 60'(bt)};
      a_k[0] = 8'hFF;
      a_l[0] = (bt == 2);
      #1;
      chk($sformatf("single%0d_tvalid", c),
          64'(o_v[0]), 64'(c >= 1 && c <= 3));
      chk($sformatf("single%0d_b_tready", c),
          64'(b_r[0]), 64'd0);
      if (c >= 1 && c <= 3) begin
        chk($sformatf("single%0d_tdata", c),
            o_d[0], {4'hA, 60'h100 + 60'(c - 1)});
        chk($sformatf("single%0d_tlast", c),
            64'(o_l[0]), 64'(c == 3));
      end
      tick();
    end
    idle_in(0);
    #1;
    chk("single_cnt_a", 64'(ca[0]), 64'd3);
    chk("single_cnt_b", 64'(cb[0]), 64'd2);

    // Gap insertion, IFG 4, back-to-back 1-beat frames.
    for (int c = 0; c < 12; c++) begin
      a_v[1] = 1'b1; a_l[1] = 1'b1;
      a_d[1] = {4'hA, 60'(c)}; a_k[1] = 8'h01;
      rdy[1] = 1'b1;
      #1;
      chk($sformatf("gap%0d_tvalid", c),
          64'(o_v[1]), 64'(c % 6 == 1));
      tick();
    end
    idle_in(1);
    tick();
    #1;
    chk("gap_cnt_a", 64'(ca[1]), 64'd2);

    // Counter wrap on B.
    force dut1.cnt_b_q = 32'hFFFF_FFFF;
    #1;
    release dut1.cnt_b_q;
    m_cb[1] = 32'hFFFF_FFFF;
    chk("wrap_preset", 64'(cb[1]), 64'hFFFF_FFFF);
    b_v[1] = 1'b1; b_l[1] = 1'b1;
    b_d[1] = {4'hB, 60'h7}; b_k[1] = 8'h03;
    tick();
    tick();
    idle_in(1);
    #1;
    chk("wrap_cnt_b", 64'(cb[1]), 64'd0);
    chk("wrap_cnt_a", 64'(ca[1]), 64'd2);
    for (int c = 0; c < 5; c++) tick();

    // Backpressure: 5 stall cycles mid-frame.
    bt = 0;
    rc = 0;
    for (int c = 0; c < 12; c++) begin
      a_v[0] = (bt < 4);
      a_d[0] = {4'hA, 60'h200 + 60'(bt)};
      a_k[0] = 8'hFF;
      a_l[0] = (bt == 3);
      rdy[0] = !(c >= 3 && c <= 7);
      b_v[0] = (c >= 3 && c <= 7);
      b_l[0] = 1'b1;
      b_d[0] = {4'hB, 60'h200};
      #1;
      if (c >= 1 && c <= 9) begin
        chk($sformatf("bp%0d_a_tready", c),
            64'(a_r[0]), 64'(rdy[0]));
        chk($sformatf("bp%0d_b_tready", c),
            64'(b_r[0]), 64'd0);
      end
      if (c >= 3 && c <= 7) begin
        chk($sformatf("bp%0d_hold_valid", c),
            64'(o_v[0]), 64'd1);
      end
      if (o_v[0] && rdy[0]) begin
        chk($sformatf("bp_beat%0d", rc), o_d[0],
            {4'hA, 60'h200 + 60'(rc)});
        rc++;
      end
      tick();
      if (hs_a[0]) bt++;
    end
    idle_in(0);
    #1;
    chk("bp_beats", 64'(rc), 64'd4);
    chk("bp_cnt_a", 64'(ca[0]), 64'd4);
    tick();

    // Reset on beat 2 of a 4-beat A frame.
    for (int c = 0; c < 3; c++) begin
      a_v[0] = 1'b1; a_l[0] = 1'b0;
      a_d[0] = {4'hA, 60'h300 + 60'(c)};
      a_k[0] = 8'hFF;
      rst = (c == 2);
      tick();
    end
    idle_in(0);
    rst = 1'b1;
    #1;
    chk("mrst_tvalid", 64'(o_v[0]), 64'd0);
    chk("mrst_tdata", o_d[0], 64'd0);
    chk("mrst_tkeep", 64'(o_k[0]), 64'd0);
    chk("mrst_tlast", 64'(o_l[0]), 64'd0);
    chk("mrst_a_tready", 64'(a_r[0]), 64'd0);
    chk("mrst_cnt_a", 64'(ca[0]), 64'd0);
    chk("mrst_cnt_b", 64'(cb[0]), 64'd0);
    chk("mrst_cnt_a1", 64'(ca[1]), 64'd0);
    tick();
    rst = 1'b0;
    a_v[0] = 1'b1; b_v[0] = 1'b1;
    a_d[0] = {4'hA, 60'h3A0}; a_k[0] = 8'hFF;
    b_d[0] = {4'hB, 60'h3B0}; b_k[0] = 8'h0F;
    tick();
    b_v[0] = 1'b0;
    a_l[0] = 1'b1;
    #1;
    chk("mrst_tie_a_tready", 64'(a_r[0]), 64'd1);
    chk("mrst_tie_b_tready", 64'(b_r[0]), 64'd0);
    chk("mrst_tie_tdata", o_d[0], {4'hA, 60'h3A0});
    tick();
    idle_in(0);
    #1;
    chk("mrst_after_cnt_a", 64'(ca[0]), 64'd1);
    tick();

    // Random traffic on both instances.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        slen[i][s] = $urandom_range(1, 4);
        sbt[i][s] = 0;
        sfr[i][s] = 0;
        sdone[i][s] = 0;
      end
    end
    for (int n = 0; n < 1500; n++) begin
      drive_rand(0);
      drive_rand(1);
      tick();
      advance_rand(0);
      advance_rand(1);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rand_u%0d_cnt_a", i),
          64'(ca[i]), 64'(sdone[i][0]));
      chk($sformatf("rand_u%0d_cnt_b", i),
          64'(cb[i]), 64'(sdone[i][1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
